seg7_scan_capture: RTL and testbench

Receive-side companion of the multiplexed 7-segment display driver. Samples the time-multiplexed `seg`/`scan` bus, rejects transition ghosting, decodes each segment pattern back to a BCD digit, and reassembles complete 8-digit frames. Serves as an on-chip self-check monitor for the display path and as the bench's display observer.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_scan_capture.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path: segment patterns
// (gfedcba, 1 = lit), special digit codes and the number of positions.
package seg7_pkg;

    localparam int NUM_POS = 8;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the segment encoder: normalised pattern to
// BCD code, with flags for a dark digit and an unrecognised pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       blank,
    output logic       err
);

    // Pattern lookup; anything not in the table is reported as invalid.
    always_comb begin
        code  = CODE_INVALID;
        blank = 1'b0;
        err   = 1'b0;
        case (pattern)
            7'h00:   begin code = CODE_BLANK; blank = 1'b1; end
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            default: begin code = CODE_INVALID; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Display-bus observer: samples the multiplexed seg/scan lines, waits for
// each dwell to settle, decodes it and assembles complete 8-digit frames.
//
// Output handshake: frame_valid is a single-cycle strobe with no
// backpressure. frame_digits/frame_blank/frame_err change only in the cycle
// frame_valid is high and hold until the next strobe or clr.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE          = 4,
    parameter int SCAN_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  seg,
    input  logic [7:0]  scan,
    output logic [31:0] frame_digits,
    output logic [7:0]  frame_blank,
    output logic        frame_err,
    output logic        frame_valid,
    output logic        scan_err
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [7:0]  norm_scan;
    logic [6:0]  norm_seg;
    logic [7:0]  r_scan;
    logic [6:0]  r_seg;
    logic        loaded;
    logic        same;
    logic [7:0]  cnt;
    logic        capture;
    logic        onehot;
    logic [2:0]  pos;
    logic [3:0]  dec_code;
    logic        dec_blank;
    logic        dec_err;
    logic [31:0] work;
    logic [7:0]  blank_w;
    logic [7:0]  err_w;
    logic [7:0]  seen;
    logic [31:0] work_m;
    logic [7:0]  blank_m;
    logic [7:0]  err_m;
    logic [7:0]  seen_m;
    logic        take;
    logic        complete;

    assign norm_scan = (SCAN_ACTIVE_LOW != 0) ? ~scan : scan;
    assign norm_seg  = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;

    // Input register; 'loaded' keeps the first sample after reset from
    // being compared against the reset value of r.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_scan <= '0;
            r_seg  <= '0;
            loaded <= 1'b0;
        end else begin
            r_scan <= norm_scan;
            r_seg  <= norm_seg;
            loaded <= 1'b1;
        end
    end

    assign same    = loaded && ({norm_scan, norm_seg} == {r_scan, r_seg});
    // Fires once per dwell: a saturated counter never passes SETTLE-1 again.
    assign capture = same && (cnt == SETTLE_M1);

    // Stability counter, saturating at SETTLE, cleared on any change.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (!same) begin
            cnt <= '0;
        end else if (cnt != SETTLE_C) begin
            cnt <= cnt + 8'd1;
        end
    end

    // One-hot check and index of the selected position.
    always_comb begin
        onehot = (r_scan != 8'd0) && ((r_scan & (r_scan - 8'd1)) == 8'd0);
        pos    = 3'd0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (r_scan[i]) pos = 3'(i);
        end
    end

    seg7_decode u_decode (
        .pattern (r_seg),
        .code    (dec_code),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    // Work state merged with the digit being captured this cycle, so the
    // completing digit lands in the frame outputs on the same edge.
    always_comb begin
        work_m               = work;
        blank_m              = blank_w;
        err_m                = err_w;
        seen_m               = seen;
        work_m[4*pos +: 4]   = dec_code;
        blank_m[pos]         = dec_blank;
        err_m[pos]           = dec_err;
        seen_m[pos]          = 1'b1;
    end

    assign take     = capture && onehot;
    assign complete = take && (seen_m == 8'hFF);

    // Per-position work arrays; seen/err restart after each completed frame.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            work    <= '0;
            blank_w <= '0;
            err_w   <= '0;
            seen    <= '0;
        end else if (take) begin
            work    <= work_m;
            blank_w <= blank_m;
            if (complete) begin
                seen  <= '0;
                err_w <= '0;
            end else begin
                seen  <= seen_m;
                err_w <= err_m;
            end
        end
    end

    // Frame output registers and the completion strobe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_digits <= '0;
            frame_blank  <= '0;
            frame_err    <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            frame_valid <= complete;
            if (complete) begin
                frame_digits <= work_m;
                frame_blank  <= blank_m;
                frame_err    <= |err_m;
            end
        end
    end

    // Sticky flag for a settled dwell with no or several selects active.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            scan_err <= 1'b0;
        end else if (capture && !onehot) begin
            scan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed frames on an active-low bus, a
// queue of expected frames checked on every frame_valid, plus SETTLE=1/255
// capture-edge sweeps on two extra instances.
module tb_seg7_scan_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;

    // main DUT (SETTLE = 4)
    logic        clr;
    logic [6:0]  seg;
    logic [7:0]  scan;
    logic [31:0] frame_digits;
    logic [7:0]  frame_blank;
    logic        frame_err;
    logic        frame_valid;
    logic        scan_err;

    // sweep DUTs share one input bus and one reset
    logic        s_clr;
    logic [6:0]  s_seg;
    logic [7:0]  s_scan;
    logic [31:0] a_digits, b_digits;
    logic [7:0]  a_blank, b_blank;
    logic        a_err, b_err, a_valid, b_valid, a_serr, b_serr;

    logic [40:0] exp_q[$];

    seg7_scan_capture #(.SETTLE(4), .SCAN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .clr(clr), .seg(seg), .scan(scan),
        .frame_digits(frame_digits), .frame_blank(frame_blank),
        .frame_err(frame_err), .frame_valid(frame_valid), .scan_err(scan_err)
    );

    seg7_scan_capture #(.SETTLE(1), .SCAN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_s1 (
        .clk(clk), .clr(s_clr), .seg(s_seg), .scan(s_scan),
        .frame_digits(a_digits), .frame_blank(a_blank),
        .frame_err(a_err), .frame_valid(a_valid), .scan_err(a_serr)
    );

    seg7_scan_capture #(.SETTLE(255), .SCAN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_s255 (
        .clk(clk), .clr(s_clr), .seg(s_seg), .scan(s_scan),
        .frame_digits(b_digits), .frame_blank(b_blank),
        .frame_err(b_err), .frame_valid(b_valid), .scan_err(b_serr)
    );

    // bench-side segment table (gfedcba, 1 = lit)
    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'h3F; 1: pat = 7'h06; 2: pat = 7'h5B; 3: pat = 7'h4F;
            4: pat = 7'h66; 5: pat = 7'h6D; 6: pat = 7'h7D; 7: pat = 7'h07;
            8: pat = 7'h7F; default: pat = 7'h6F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present position p with normalised pattern pn for n cycles (raw is active-low)
    task automatic show(input int p, input logic [6:0] pn, input int n);
        scan = ~(8'h01 << p);
        seg  = ~pn;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [31:0] d, input logic [7:0] b, input logic e);
        exp_q.push_back({d, b, e});
    endtask

    // scoreboard: every frame_valid pops one expected frame
    always @(posedge clk) begin
        logic [40:0] e;
        #1;
        if (frame_valid) begin
            fv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_digits", 64'(frame_digits), 64'(e[40:9]));
                check("frame_blank", 64'(frame_blank), 64'(e[8:1]));
                check("frame_err", 64'(frame_err), 64'(e[0]));
            end
        end
    end

    // frame of 8 positions then measure edges until frame_valid on one sweep DUT
    task automatic sweep(input int s);
        int hit;
        logic v;
        logic [31:0] d;
        s_scan = ~8'h01;
        s_seg  = ~pat(0);
        s_clr  = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        for (int p = 0; p < 7; p++) begin
            s_scan = ~(8'h01 << p);
            s_seg  = ~pat(p);
            repeat (s + 3) @(negedge clk);
        end
        s_scan = ~8'h80;
        s_seg  = ~pat(7);
        hit = 0;
        d = '0;
        for (int k = 1; k <= s + 10; k++) begin
            @(posedge clk);
            #1;
            v = (s == 1) ? a_valid : b_valid;
            if (v && hit == 0) begin
                hit = k;
                d = (s == 1) ? a_digits : b_digits;
            end
        end
        check($sformatf("sweep_edge_S%0d", s), 64'(hit), 64'(s + 1));
        check($sformatf("sweep_digits_S%0d", s), 64'(d), 64'h76543210);
        @(negedge clk);
    endtask

    initial begin
        int d1[8];
        clr = 1'b1; scan = 8'hFF; seg = 7'h7F;
        s_clr = 1'b1; s_scan = 8'hFF; s_seg = 7'h7F;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_digits", 64'(frame_digits), 64'd0);
        check("rst_blank", 64'(frame_blank), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_scan_err", 64'(scan_err), 64'd0);

        // frame 1: 1,2,3,4,5,9,0,8
        d1 = '{1, 2, 3, 4, 5, 9, 0, 8};
        scan = ~8'h01; seg = ~pat(1);
        clr = 1'b0;
        push_frame(32'h80954321, 8'h00, 1'b0);
        for (int p = 0; p < 8; p++) show(p, pat(d1[p]), 10);
        check("fv_after_frame1", 64'(fv_count), 64'd1);

        // frame 2: position 3 glitch of 4 cycles is ignored
        show(0, pat(7), 10);
        show(1, pat(6), 10);
        show(2, pat(5), 10);
        show(3, pat(2), 4);
        show(4, pat(1), 10);
        show(5, pat(0), 10);
        show(6, pat(9), 10);
        show(7, pat(3), 10);
        check("fv_short_dwell", 64'(fv_count), 64'd1);
        push_frame(32'h39014567, 8'h00, 1'b0);
        show(3, pat(4), 5);
        check("fv_after_frame2", 64'(fv_count), 64'd2);

        // frame 3: blank at 6, invalid at 2
        push_frame(32'h8F654E21, 8'h40, 1'b1);
        show(0, pat(1), 10);
        show(1, pat(2), 10);
        show(2, 7'h01, 10);
        show(3, pat(4), 10);
        show(4, pat(5), 10);
        show(5, pat(6), 10);
        show(6, 7'h00, 10);
        show(7, pat(8), 10);

        // frame 4: clean again, position 0 captured twice (last wins)
        push_frame(32'h76543210, 8'h00, 1'b0);
        show(0, pat(9), 10);
        for (int p = 1; p < 7; p++) show(p, pat(p), 10);
        show(0, pat(0), 10);
        show(7, pat(7), 10);
        check("fv_after_frame4", 64'(fv_count), 64'd4);

        // multi-hot scan sets sticky scan_err
        check("scan_err_before", 64'(scan_err), 64'd0);
        scan = 8'hFC; seg = ~pat(3);
        repeat (6) @(negedge clk);
        check("scan_err_set", 64'(scan_err), 64'd1);
        push_frame(32'h55555555, 8'h00, 1'b0);
        for (int p = 0; p < 8; p++) show(p, pat(5), 10);
        check("scan_err_sticky", 64'(scan_err), 64'd1);
        check("fv_after_frame5", 64'(fv_count), 64'd5);

        // async clear after 5 captured positions
        for (int p = 0; p < 5; p++) show(p, pat(9 - p), 10);
        scan = ~8'h20; seg = ~pat(6);
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_digits", 64'(frame_digits), 64'd0);
        check("clr_blank", 64'(frame_blank), 64'd0);
        check("clr_err", 64'(frame_err), 64'd0);
        check("clr_valid", 64'(frame_valid), 64'd0);
        check("clr_scan_err", 64'(scan_err), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        show(5, pat(6), 10);
        show(6, pat(7), 10);
        show(7, pat(8), 10);
        check("fv_after_clr_partial", 64'(fv_count), 64'd5);
        push_frame(32'h87643210, 8'h00, 1'b0);
        for (int p = 0; p < 5; p++) show(p, pat(p), 10);
        check("fv_after_frame6", 64'(fv_count), 64'd6);
        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        // capture-edge sweep for SETTLE extremes
        sweep(1);
        sweep(255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
